// File: rtl/delay_wakeup_mc_if.sv
// Arm/cancel/event bundle for delay_wakeup_mc.
// DWAKE_PERIODIC_EN adds the arm_periodic request bit.
interface delay_wakeup_mc_if #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_IDX_W = 2,
  parameter int unsigned CNT_W    = 8
);
  logic                arm_valid;
  logic                arm_ready;
  logic [CH_IDX_W-1:0] arm_ch;
  logic [CNT_W-1:0]    arm_delay;
`ifdef DWAKE_PERIODIC_EN
  logic                arm_periodic;
`endif
  logic [NUM_CH-1:0]   cancel;
  logic [NUM_CH-1:0]   busy;
  logic [NUM_CH-1:0]   wake;
  logic                evt_valid;
  logic [CH_IDX_W-1:0] evt_ch;
  logic                evt_ready;

`ifdef DWAKE_PERIODIC_EN
  modport master (
    output arm_valid, arm_ch, arm_delay, arm_periodic, cancel, evt_ready,
    input  arm_ready, busy, wake, evt_valid, evt_ch
  );
  modport slave (
    input  arm_valid, arm_ch, arm_delay, arm_periodic, cancel, evt_ready,
    output arm_ready, busy, wake, evt_valid, evt_ch
  );
`else
  modport master (
    output arm_valid, arm_ch, arm_delay, cancel, evt_ready,
    input  arm_ready, busy, wake, evt_valid, evt_ch
  );
  modport slave (
    input  arm_valid, arm_ch, arm_delay, cancel, evt_ready,
    output arm_ready, busy, wake, evt_valid, evt_ch
  );
`endif
endinterface

// File: rtl/delay_wakeup_mc.sv
// Multi-channel delay-wakeup timer with a lowest-index-first event port.
// Optional DWAKE_PERIODIC_EN: channels can reload their delay after each event.
module delay_wakeup_mc #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_IDX_W = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  delay_wakeup_mc_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_PEND  = 2'd2
  } state_t;

  state_t              st      [NUM_CH];
  state_t              st_nxt  [NUM_CH];
  logic [CNT_W-1:0]    cnt     [NUM_CH];
  logic [CNT_W-1:0]    cnt_nxt [NUM_CH];
  logic [NUM_CH-1:0]   arm_acc;
  logic [NUM_CH-1:0]   wake_nxt;
  logic [NUM_CH-1:0]   busy_nxt;
  logic [NUM_CH-1:0]   busy_q;
  logic [NUM_CH-1:0]   wake_q;
  logic                evt_valid_q;
  logic [CH_IDX_W-1:0] evt_ch_q;
  logic                evt_valid_nxt;
  logic [CH_IDX_W-1:0] evt_ch_nxt;
  logic                arm_ok;
  logic                hs;
`ifdef DWAKE_PERIODIC_EN
  logic [CNT_W-1:0]    reload [NUM_CH];
  logic [NUM_CH-1:0]   periodic;
`endif

  assign bus.arm_ready = arm_ok;
  assign bus.busy      = busy_q;
  assign bus.wake      = wake_q;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_ch    = evt_ch_q;
  assign hs            = evt_valid_q && bus.evt_ready;

  // Out-of-range arm_ch matches no channel, so arm_ready stays low.
  always_comb begin
    arm_ok  = 1'b0;
    arm_acc = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.arm_ch == CH_IDX_W'(i)) begin
        arm_ok     = (st[i] == S_IDLE) && !bus.cancel[i];
        arm_acc[i] = bus.arm_valid && arm_ok;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      st_nxt[i]   = st[i];
      cnt_nxt[i]  = cnt[i];
      wake_nxt[i] = 1'b0;
      if (bus.cancel[i]) begin
        st_nxt[i]  = S_IDLE;
        cnt_nxt[i] = '0;
      end else begin
        case (st[i])
          S_IDLE: begin
            if (arm_acc[i]) begin
              st_nxt[i]  = S_COUNT;
              cnt_nxt[i] = bus.arm_delay;
            end
          end
          S_COUNT: begin
            if (cnt[i] == '0) begin
              st_nxt[i]   = S_PEND;
              wake_nxt[i] = 1'b1;
            end else begin
              cnt_nxt[i] = cnt[i] - 1'b1;
            end
          end
          S_PEND: begin
            if (hs && evt_ch_q == CH_IDX_W'(i)) begin
`ifdef DWAKE_PERIODIC_EN
              if (periodic[i]) begin
                st_nxt[i]  = S_COUNT;
                cnt_nxt[i] = reload[i];
              end else begin
                st_nxt[i] = S_IDLE;
              end
`else
              st_nxt[i] = S_IDLE;
`endif
            end
          end
          default: begin
            st_nxt[i]  = S_IDLE;
            cnt_nxt[i] = '0;
          end
        endcase
      end
      busy_nxt[i] = (st_nxt[i] != S_IDLE);
    end
  end

  // Lowest pending channel wins, except a stalled grant is held while it stays pending.
  always_comb begin
    evt_valid_nxt = 1'b0;
    evt_ch_nxt    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (st_nxt[i] == S_PEND && !evt_valid_nxt) begin
        evt_valid_nxt = 1'b1;
        evt_ch_nxt    = CH_IDX_W'(i);
      end
    end
    if (evt_valid_q && !bus.evt_ready) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (evt_ch_q == CH_IDX_W'(i) && st_nxt[i] == S_PEND) begin
          evt_ch_nxt = evt_ch_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        st[i]  <= S_IDLE;
        cnt[i] <= '0;
`ifdef DWAKE_PERIODIC_EN
        reload[i] <= '0;
`endif
      end
`ifdef DWAKE_PERIODIC_EN
      periodic <= '0;
`endif
      busy_q      <= '0;
      wake_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        st[i]  <= st_nxt[i];
        cnt[i] <= cnt_nxt[i];
`ifdef DWAKE_PERIODIC_EN
        if (arm_acc[i]) begin
          reload[i]   <= bus.arm_delay;
          periodic[i] <= bus.arm_periodic;
        end
`endif
      end
      busy_q      <= busy_nxt;
      wake_q      <= wake_nxt;
      evt_valid_q <= evt_valid_nxt;
      evt_ch_q    <= evt_ch_nxt;
    end
  end

endmodule

// File: tb/tb_delay_wakeup_mc.sv
// Directed plus randomized bench for delay_wakeup_mc against a deadline-based reference model.
module tb_delay_wakeup_mc;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  delay_wakeup_mc_if #(.NUM_CH(4), .CH_IDX_W(2), .CNT_W(8)) bus ();

  delay_wakeup_mc #(.NUM_CH(4), .CH_IDX_W(2), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a counting channel becomes pending at an absolute edge number.
  bit         m_cnt  [4];
  bit         m_pend [4];
  int         m_due  [4];
  logic [3:0] m_wake;
  logic [3:0] m_busy;
  logic       m_ev;
  logic [1:0] m_ech;
  int         t;
  bit         known;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic av, input logic [1:0] ch, input logic [7:0] d,
                      input logic [3:0] cn, input logic er, input logic r);
    logic exp_ready;
    logic acc;
    logic hs;
    logic stalled;
    @(negedge clk);
    bus.arm_valid = av;
    bus.arm_ch    = ch;
    bus.arm_delay = d;
    bus.cancel    = cn;
    bus.evt_ready = er;
    rst           = r;
    #1;
    exp_ready = !m_cnt[ch] && !m_pend[ch] && !cn[ch];
    if (known) chk("arm_ready", 32'(bus.arm_ready), 32'(exp_ready));
    acc = av && exp_ready;
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i]  = 0;
        m_pend[i] = 0;
      end
      m_wake = '0;
      m_ev   = 1'b0;
      m_ech  = '0;
      known  = 1;
    end else begin
      hs = m_ev && er;
      for (int i = 0; i < 4; i++) begin
        m_wake[i] = 1'b0;
        if (cn[i]) begin
          m_cnt[i]  = 0;
          m_pend[i] = 0;
        end else if (m_pend[i]) begin
          if (hs && m_ech == 2'(i)) m_pend[i] = 0;
        end else if (m_cnt[i]) begin
          if (t == m_due[i]) begin
            m_cnt[i]  = 0;
            m_pend[i] = 1;
            m_wake[i] = 1'b1;
          end
        end else if (acc && ch == 2'(i)) begin
          m_cnt[i] = 1;
          m_due[i] = t + int'(d) + 1;
        end
      end
      stalled = m_ev && !er;
      if (!(stalled && m_pend[m_ech])) begin
        m_ev  = 1'b0;
        m_ech = '0;
        for (int i = 3; i >= 0; i--) begin
          if (m_pend[i]) begin
            m_ev  = 1'b1;
            m_ech = 2'(i);
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) m_busy[i] = m_cnt[i] | m_pend[i];
    t++;
    #1;
    chk("busy",      32'(bus.busy),      32'(m_busy));
    chk("wake",      32'(bus.wake),      32'(m_wake));
    chk("evt_valid", 32'(bus.evt_valid), 32'(m_ev));
    chk("evt_ch",    32'(bus.evt_ch),    32'(m_ech));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    t     = 0;
    known = 0;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]  = 0;
      m_pend[i] = 0;
      m_due[i]  = 0;
    end
    m_wake = '0;
    m_busy = '0;
    m_ev   = 1'b0;
    m_ech  = '0;
    rst           = 1'b0;
    bus.arm_valid = 1'b0;
    bus.arm_ch    = '0;
    bus.arm_delay = '0;
    bus.cancel    = '0;
    bus.evt_ready = 1'b0;
`ifdef DWAKE_PERIODIC_EN
    bus.arm_periodic = 1'b0;
`endif

    // Reset for three cycles
    repeat (3) step(1'b0, 2'd0, 8'd0, 4'b0000, 1'b0, 1'b0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // Ch1 D=5: wake on the sixth edge after acceptance
    step(1'b1, 2'd1, 8'd5, 4'b0000, 1'b0, 1'b1);
    repeat (5) step(1'b0, 2'd0, 8'd0, 4'b0000, 1'b0, 1'b1);
    chk("t1_wake_early", 32'(bus.wake), 32'd0);
    step(1'b0, 2'd0, 8'd0, 4'b0000, 1'b0, 1'b1);
    chk("t1_wake", 32'(bus.wake[1]), 32'd1);
    chk("t1_evt_ch", 32'(bus.evt_ch), 32'd1);
    step(1'b0, 2'd0, 8'd0, 4'b0000, 1'b1, 1'b1);

    // Ch0 D=0, stalled consumer, then retire
    step(1'b1, 2'd0, 8'd0, 4'b0000, 1'b0, 1'b1);
    step(1'b0, 2'd0, 8'd0, 4'b0000, 1'b0, 1'b1);
    chk("t2_wake", 32'(bus.wake[0]), 32'd1);
    repeat (4) step(1'b0, 2'd0, 8'd0, 4'b0000, 1'b0, 1'b1);
    chk("t2_stall_valid", 32'(bus.evt_valid), 32'd1);
    step(1'b0, 2'd0, 8'd0, 4'b0000, 1'b1, 1'b1);
    chk("t2_busy0", 32'(bus.busy[0]), 32'd0);

    // Ch2 and ch3 back-to-back
    step(1'b1, 2'd2, 8'd3, 4'b0000, 1'b1, 1'b1);
    step(1'b1, 2'd3, 8'd3, 4'b0000, 1'b1, 1'b1);
    repeat (7) step(1'b0, 2'd0, 8'd0, 4'b0000, 1'b1, 1'b1);

    // Ch1 D=4 cancelled on its terminal count cycle, then re-armed
    step(1'b1, 2'd1, 8'd4, 4'b0000, 1'b1, 1'b1);
    repeat (4) step(1'b0, 2'd0, 8'd0, 4'b0000, 1'b1, 1'b1);
    step(1'b0, 2'd0, 8'd0, 4'b0010, 1'b1, 1'b1);
    chk("t4_nowake", 32'(bus.wake[1]), 32'd0);
    step(1'b1, 2'd1, 8'd4, 4'b0000, 1'b1, 1'b1);
    chk("t4_rearm", 32'(bus.busy[1]), 32'd1);

    // Busy re-arm refused, then mid-flight reset
    step(1'b1, 2'd0, 8'd10, 4'b0000, 1'b1, 1'b1);
    repeat (2) step(1'b0, 2'd0, 8'd0, 4'b0000, 1'b1, 1'b1);
    step(1'b1, 2'd0, 8'd2, 4'b0000, 1'b1, 1'b1);
    repeat (2) step(1'b0, 2'd0, 8'd0, 4'b0000, 1'b1, 1'b1);
    step(1'b0, 2'd0, 8'd0, 4'b0000, 1'b1, 1'b0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    repeat (15) step(1'b0, 2'd0, 8'd0, 4'b0000, 1'b1, 1'b1);

    // Maximum delay
    step(1'b1, 2'd3, 8'd255, 4'b0000, 1'b1, 1'b1);
    repeat (258) step(1'b0, 2'd0, 8'd0, 4'b0000, 1'b1, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] cn;
      for (int i = 0; i < 4; i++) cn[i] = ($urandom_range(0, 15) == 0);
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 12)),
           cn, ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
